mcu_spi_responder: RTL and testbench

MCU_SPI_RESPONDER -- requirements
Module: mcu_spi_responder

---
 rtl/mcu_spi_pkg.sv | 20 ++
 rtl/mcu_spi_responder_if.sv | 21 ++
 rtl/ps2_byte_fifo.sv | 57 +++++
 rtl/mcu_spi_responder.sv | 213 +++++++++++++++++++++
 tb/tb_mcu_spi_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_spi_pkg.sv
// Shared constants and types for the MCU SPI responder: command codes, FIFO default depth
// and the transfer state encoding.
package mcu_spi_pkg;

    localparam int unsigned FifoDepthDefault = 4;

    localparam logic [7:0] CmdButtons = 8'h01;
    localparam logic [7:0] CmdJoy0    = 8'h02;
    localparam logic [7:0] CmdJoy1    = 8'h03;
    localparam logic [7:0] CmdKbd     = 8'h05;
    localparam logic [7:0] CmdMouse   = 8'h06;
    localparam logic [7:0] CmdStatus  = 8'h15;

    typedef enum logic [1:0] {
        StWaitIdle,
        StCmd,
        StData
    } xfer_state_e;

endpackage

// File: rtl/mcu_spi_responder_if.sv
// SPI bus between the MCU (master modport) and the guest-side responder (slave modport).
interface mcu_spi_responder_if;
    logic spi_sck;
    logic spi_di;
    logic spi_do;
    logic conf_data0;

    modport master (
        output spi_sck,
        output spi_di,
        output conf_data0,
        input  spi_do
    );

    modport slave (
        input  spi_sck,
        input  spi_di,
        input  conf_data0,
        output spi_do
    );
endinterface

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module ps2_byte_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned   PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DepthCnt);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
        count_d  = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: rdata is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mcu_spi_responder.sv
// MCU SPI command responder: latches buttons/joysticks, streams keyboard bytes, returns status.
// Define PS2_MOUSE_EN to add a mouse byte FIFO fed by command 0x06.
module mcu_spi_responder
    import mcu_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
    input  logic               clk,
    input  logic               reset_n,
    mcu_spi_responder_if.slave spi,
    input  logic [7:0]         core_status,
    output logic [7:0]         buttons,
    output logic [7:0]         joystick_0,
    output logic [7:0]         joystick_1,
    output logic [7:0]         kbd_data,
    output logic               kbd_valid,
    input  logic               kbd_ready,
    output logic               kbd_overflow
`ifdef PS2_MOUSE_EN
    ,
    output logic [7:0]         mouse_data,
    output logic               mouse_valid,
    input  logic               mouse_ready,
    output logic               mouse_overflow
`endif
);

    logic [1:0]  sck_sync_q, sck_sync_d;
    logic [1:0]  di_sync_q, di_sync_d;
    logic [1:0]  cs_sync_q, cs_sync_d;
    logic        sck_prev_q, sck_prev_d;
    xfer_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  tx_q, tx_d;
    logic        spi_do_q, spi_do_d;
    logic [7:0]  buttons_q, buttons_d;
    logic [7:0]  joy0_q, joy0_d;
    logic [7:0]  joy1_q, joy1_d;
    logic        kbd_ovf_q, kbd_ovf_d;

    logic        sck_s, di_s, cs_s, sck_rise, sck_fall;
    logic [7:0]  rx_byte;
    logic        kbd_push, kbd_pop, kbd_full, kbd_empty;
`ifdef PS2_MOUSE_EN
    logic        mouse_push, mouse_pop, mouse_full, mouse_empty;
    logic        mouse_ovf_q, mouse_ovf_d;
`endif

    assign sck_s    = sck_sync_q[1];
    assign di_s     = di_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_byte  = {shift_q, di_s};

    always_comb begin
        sck_sync_d = {sck_sync_q[0], spi.spi_sck};
        di_sync_d  = {di_sync_q[0], spi.spi_di};
        cs_sync_d  = {cs_sync_q[0], spi.conf_data0};
        sck_prev_d = sck_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        buttons_d  = buttons_q;
        joy0_d     = joy0_q;
        joy1_d     = joy1_q;
        kbd_push   = 1'b0;
`ifdef PS2_MOUSE_EN
        mouse_push = 1'b0;
`endif

        if (cs_s) begin
            // Deselect arms the receiver and drops any partial byte.
            state_d   = StCmd;
            bit_cnt_d = '0;
            shift_d   = '0;
            cmd_d     = '0;
            idx_d     = '0;
        end else if (state_q != StWaitIdle) begin
            if (sck_rise) begin
                shift_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == StCmd) begin
                        state_d = StData;
                        cmd_d   = rx_byte;
                        idx_d   = '0;
                        if (rx_byte == CmdStatus) begin
                            tx_d = core_status;
                        end
                    end else begin
                        case (cmd_q)
                            CmdButtons: if (idx_q == 8'd0) buttons_d = rx_byte;
                            CmdJoy0:    if (idx_q == 8'd0) joy0_d = rx_byte;
                            CmdJoy1:    if (idx_q == 8'd0) joy1_d = rx_byte;
                            CmdKbd:     kbd_push = 1'b1;
`ifdef PS2_MOUSE_EN
                            CmdMouse:   mouse_push = 1'b1;
`endif
                            CmdStatus:  tx_d = core_status;
                            default:    ;
                        endcase
                        if (idx_q != 8'hFF) begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
            end else if (sck_fall && bit_cnt_q != 3'd0 && state_q == StData) begin
                // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
                tx_d = {tx_q[6:0], 1'b0};
            end
        end

        spi_do_d = (state_d == StData && cmd_d == CmdStatus) ? tx_d[7] : 1'b0;
    end

    assign kbd_pop   = kbd_ready & ~kbd_empty;
    assign kbd_ovf_d = kbd_ovf_q | (kbd_push & kbd_full & ~kbd_pop);

    ps2_byte_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (kbd_push),
        .pop     (kbd_pop),
        .wdata   (rx_byte),
        .rdata   (kbd_data),
        .full    (kbd_full),
        .empty   (kbd_empty)
    );

`ifdef PS2_MOUSE_EN
    assign mouse_pop   = mouse_ready & ~mouse_empty;
    assign mouse_ovf_d = mouse_ovf_q | (mouse_push & mouse_full & ~mouse_pop);

    ps2_byte_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_mouse_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (mouse_push),
        .pop     (mouse_pop),
        .wdata   (rx_byte),
        .rdata   (mouse_data),
        .full    (mouse_full),
        .empty   (mouse_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mouse_ovf_q <= 1'b0;
        end else begin
            mouse_ovf_q <= mouse_ovf_d;
        end
    end

    assign mouse_valid    = ~mouse_empty;
    assign mouse_overflow = mouse_ovf_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            di_sync_q  <= '0;
            cs_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            state_q    <= StWaitIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            idx_q      <= '0;
            tx_q       <= '0;
            spi_do_q   <= 1'b0;
            buttons_q  <= '0;
            joy0_q     <= '0;
            joy1_q     <= '0;
            kbd_ovf_q  <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            di_sync_q  <= di_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            spi_do_q   <= spi_do_d;
            buttons_q  <= buttons_d;
            joy0_q     <= joy0_d;
            joy1_q     <= joy1_d;
            kbd_ovf_q  <= kbd_ovf_d;
        end
    end

    assign spi.spi_do   = spi_do_q;
    assign buttons      = buttons_q;
    assign joystick_0   = joy0_q;
    assign joystick_1   = joy1_q;
    assign kbd_valid    = ~kbd_empty;
    assign kbd_overflow = kbd_ovf_q;

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Directed bench for mcu_spi_responder: a byte-level transaction model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mcu_spi_responder;
    import mcu_spi_pkg::*;

    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] core_status;
    logic [7:0] buttons, joystick_0, joystick_1, kbd_data;
    logic       kbd_valid, kbd_ready, kbd_overflow;
`ifdef PS2_MOUSE_EN
    logic [7:0] mouse_data;
    logic       mouse_valid, mouse_overflow;
    logic       mouse_ready = 1'b0;
`endif

    always #5 clk = ~clk;

    mcu_spi_responder_if spi_if ();

    mcu_spi_responder #(
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi          (spi_if),
        .core_status  (core_status),
        .buttons      (buttons),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .kbd_data     (kbd_data),
        .kbd_valid    (kbd_valid),
        .kbd_ready    (kbd_ready),
        .kbd_overflow (kbd_overflow)
`ifdef PS2_MOUSE_EN
        ,
        .mouse_data     (mouse_data),
        .mouse_valid    (mouse_valid),
        .mouse_ready    (mouse_ready),
        .mouse_overflow (mouse_overflow)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Transaction-level model of what the MCU has told the guest so far.
    logic [7:0] m_buttons, m_joy0, m_joy1;
    logic       m_ovf;
    logic [7:0] kq[$];
    bit         m_armed, m_cmd_seen, m_status;
    logic [7:0] m_cmd;
    int         m_idx;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_buttons  = 8'h00;
        m_joy0     = 8'h00;
        m_joy1     = 8'h00;
        m_ovf      = 1'b0;
        kq.delete();
        m_armed    = 1'b0;
        m_cmd_seen = 1'b0;
        m_status   = 1'b0;
        m_cmd      = 8'h00;
        m_idx      = 0;
    endfunction

    function automatic void model_cs_high();
        m_armed    = 1'b1;
        m_cmd_seen = 1'b0;
        m_status   = 1'b0;
        m_idx      = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_armed) return;
        if (!m_cmd_seen) begin
            m_cmd_seen = 1'b1;
            m_cmd      = b;
            m_idx      = 0;
            m_status   = (b == 8'h15);
        end else begin
            if (m_idx == 0 && m_cmd == 8'h01) m_buttons = b;
            if (m_idx == 0 && m_cmd == 8'h02) m_joy0 = b;
            if (m_idx == 0 && m_cmd == 8'h03) m_joy1 = b;
            if (m_cmd == 8'h05) begin
                if (kq.size() < Depth) kq.push_back(b);
                else m_ovf = 1'b1;
            end
            if (m_idx < 255) m_idx++;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("buttons", buttons, m_buttons);
            check("joystick_0", joystick_0, m_joy0);
            check("joystick_1", joystick_1, m_joy1);
            check("kbd_valid", {7'b0, kbd_valid}, {7'b0, (kq.size() != 0)});
            if (kq.size() != 0) check("kbd_data", kbd_data, kq[0]);
            check("kbd_overflow", {7'b0, kbd_overflow}, {7'b0, m_ovf});
            if (!m_status) check("spi_do_idle", {7'b0, spi_if.spi_do}, 8'h00);
        end
    end

    // Mode-0 style bit transfer at clk/8: data set, SCK high 4 clk, SCK low 4 clk.
    task automatic xfer_bits(input logic [7:0] b, input int n, input bit pop_at_last,
                             output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_if.spi_di = b[i];
            repeat (4) @(negedge clk);
            miso[i] = spi_if.spi_do;
            if (n == 8 && i == 0) chk_en = 1'b0;
            spi_if.spi_sck = 1'b1;
            if (pop_at_last && i == 0) begin
                repeat (2) @(negedge clk);
                kbd_ready = 1'b1;
                @(negedge clk);
                kbd_ready = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_if.spi_sck = 1'b0;
        end
        if (n == 8) begin
            if (pop_at_last) void'(kq.pop_front());
            model_byte(b);
            chk_en = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] m;
        xfer_bits(b, 8, 1'b0, m);
    endtask

    task automatic cs_low();
        spi_if.conf_data0 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        chk_en = 1'b0;
        spi_if.conf_data0 = 1'b1;
        repeat (4) @(negedge clk);
        model_cs_high();
        chk_en = 1'b1;
    endtask

    task automatic drain_one(input logic [7:0] exp);
        check("drain_valid", {7'b0, kbd_valid}, 8'h01);
        check("drain_data", kbd_data, exp);
        kbd_ready = 1'b1;
        @(posedge clk);
        #1 kbd_ready = 1'b0;
        void'(kq.pop_front());
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buttons"}, buttons, 8'h00);
        check({tag, "_joy0"}, joystick_0, 8'h00);
        check({tag, "_joy1"}, joystick_1, 8'h00);
        check({tag, "_kbd_data"}, kbd_data, 8'h00);
        check({tag, "_kbd_valid"}, {7'b0, kbd_valid}, 8'h00);
        check({tag, "_kbd_ovf"}, {7'b0, kbd_overflow}, 8'h00);
        check({tag, "_spi_do"}, {7'b0, spi_if.spi_do}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        spi_if.spi_sck    = 1'b0;
        spi_if.spi_di     = 1'b0;
        spi_if.conf_data0 = 1'b1;
        kbd_ready   = 1'b0;
        core_status = 8'h3C;
        reset_n     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        model_cs_high();
        chk_en = 1'b1;

        // Aborted partial byte must not misalign the next transfer.
        cs_low();
        send(8'h01);
        xfer_bits(8'hF8, 5, 1'b0, m);
        cs_high();
        cs_low();
        send(8'h01);
        send(8'h0F);
        cs_high();
        check("abort_buttons", buttons, 8'h0F);

        cs_low();
        send(8'h02);
        send(8'hA5);
        check("joy0_latched", joystick_0, 8'hA5);
        check("joy0_buttons_kept", buttons, 8'h0F);
        cs_high();

        cs_low();
        send(8'h03);
        send(8'h66);
        send(8'h77);
        cs_high();
        check("joy1_first_only", joystick_1, 8'h66);

        cs_low();
        send(8'h04);
        send(8'hEE);
        cs_high();
`ifndef PS2_MOUSE_EN
        cs_low();
        send(8'h06);
        send(8'hDD);
        cs_high();
`endif
        check("unknown_kbd_empty", {7'b0, kbd_valid}, 8'h00);

        cs_low();
        send(8'h15);
        xfer_bits(8'h00, 8, 1'b0, m);
        check("status_byte1", m, 8'h3C);
        xfer_bits(8'h00, 8, 1'b0, m);
        check("status_byte2", m, 8'h3C);
        cs_high();

        // Push into a full FIFO in the same cycle as a pop.
        cs_low();
        send(8'h05);
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
        check("full_valid", {7'b0, kbd_valid}, 8'h01);
        xfer_bits(8'h24, 8, 1'b1, m);
        check("full_pop_no_ovf", {7'b0, kbd_overflow}, 8'h00);
        cs_high();
        drain_one(8'h21);
        drain_one(8'h22);
        drain_one(8'h23);
        drain_one(8'h24);
        check("drained_empty", {7'b0, kbd_valid}, 8'h00);

        cs_low();
        send(8'h05);
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
        cs_high();
        check("overflow_set", {7'b0, kbd_overflow}, 8'h01);
        drain_one(8'h10);
        drain_one(8'h11);
        drain_one(8'h12);
        drain_one(8'h13);
        check("ovf_drained_empty", {7'b0, kbd_valid}, 8'h00);
        check("overflow_sticky", {7'b0, kbd_overflow}, 8'h01);

        // Reset in the middle of a payload byte, released with the MCU still selected.
        cs_low();
        send(8'h03);
        xfer_bits(8'hC3, 4, 1'b0, m);
        chk_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        model_reset();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        send(8'h01);
        send(8'h99);
        check("post_reset_ignored", buttons, 8'h00);
        cs_high();
        cs_low();
        send(8'h01);
        send(8'h5A);
        cs_high();
        check("post_reset_buttons", buttons, 8'h5A);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
